// File: rtl/dac_spi_sample_loader.sv
// Serial (SPI mode 0, MSB first) sample loader for the PWM DAC.
// Ports: clk/rst_n, sclk/cs_n/mosi link, period_start, clr_flags in;
//        dac_code, code_updated, pending, overrun, frame_err out.
module dac_spi_sample_loader #(
   parameter int            DW         = 12,
   parameter logic [DW-1:0] RESET_CODE = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sclk,
   input  logic          cs_n,
   input  logic          mosi,
   input  logic          period_start,
   input  logic          clr_flags,
   output logic [DW-1:0] dac_code,
   output logic          code_updated,
   output logic          pending,
   output logic          overrun,
   output logic          frame_err
);

   localparam int CW = $clog2(DW + 2);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      COMMIT
   } state_t;

   state_t state_q, state_d;

   logic sclk_q1, sclk_q2, sclk_h;
   logic cs_q1, cs_q2, cs_h;
   logic mosi_q1, mosi_q2, mosi_h;
   logic [2:0] vld_q;

   logic [DW-1:0] shift_q;
   logic [DW-1:0] buf_q;
   logic [CW-1:0] cnt_q;

   logic sclk_rise, cs_fall, cs_rise;
   logic start, shift_en, commit_ok, commit_bad;

   // Synchronisers plus one history stage each.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q1 <= 1'b0;
         sclk_q2 <= 1'b0;
         sclk_h  <= 1'b0;
         cs_q1   <= 1'b1;
         cs_q2   <= 1'b1;
         cs_h    <= 1'b1;
         mosi_q1 <= 1'b0;
         mosi_q2 <= 1'b0;
         mosi_h  <= 1'b0;
         vld_q   <= '0;
      end else begin
         sclk_q1 <= sclk;
         sclk_q2 <= sclk_q1;
         sclk_h  <= sclk_q2;
         cs_q1   <= cs_n;
         cs_q2   <= cs_q1;
         cs_h    <= cs_q2;
         mosi_q1 <= mosi;
         mosi_q2 <= mosi_q1;
         mosi_h  <= mosi_q2;
         vld_q   <= {vld_q[1:0], 1'b1};
      end
   end

   // vld_q[2] marks cs_h as carrying real link data rather than the
   // reset value, so a cs_n held low through reset is not seen as a fall.
   assign sclk_rise = sclk_q2 & ~sclk_h;
   assign cs_fall   = ~cs_q2 & cs_h & vld_q[2];
   assign cs_rise   = cs_q2 & ~cs_h;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      shift_en   = 1'b0;
      commit_ok  = 1'b0;
      commit_bad = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = RECV;
               start   = 1'b1;
            end
         end
         RECV: begin
            shift_en = sclk_rise;
            if (cs_rise) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (cnt_q == CW'(DW)) begin
               commit_ok = 1'b1;
            end else begin
               commit_bad = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Receive shifter; count saturates one past DW so long frames stay bad.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (start) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (shift_en) begin
         shift_q <= {shift_q[DW-2:0], mosi_h};
         if (cnt_q != CW'(DW + 1)) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Double buffer and DAC hand-over. A commit coinciding with
   // period_start refills the buffer just emptied, so no overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q        <= '0;
         pending      <= 1'b0;
         dac_code     <= RESET_CODE;
         code_updated <= 1'b0;
      end else begin
         code_updated <= period_start & pending;
         if (period_start && pending) begin
            dac_code <= buf_q;
         end
         if (commit_ok) begin
            buf_q   <= shift_q;
            pending <= 1'b1;
         end else if (period_start) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (commit_ok && pending && !period_start) begin
            overrun <= 1'b1;
         end else if (clr_flags) begin
            overrun <= 1'b0;
         end
         if (commit_bad) begin
            frame_err <= 1'b1;
         end else if (clr_flags) begin
            frame_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dac_spi_sample_loader.sv
// Bench for dac_spi_sample_loader: scoreboard of expected DAC codes
// checked by a monitor on code_updated, plus flag checks vs a model.
module tb_dac_spi_sample_loader;

   localparam int         DW = 12;
   localparam logic [11:0] RC = 12'h000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sclk;
   logic          cs_n;
   logic          mosi;
   logic          period_start;
   logic          clr_flags;
   logic [DW-1:0] dac_code;
   logic          code_updated;
   logic          pending;
   logic          overrun;
   logic          frame_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] exp_q[$];
   logic [11:0] pend_w;
   logic        pend_v;
   logic        ov_m;
   logic        fe_m;
   logic [11:0] dac_m;

   dac_spi_sample_loader #(.DW(DW), .RESET_CODE(RC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .mosi         (mosi),
      .period_start (period_start),
      .clr_flags    (clr_flags),
      .dac_code     (dac_code),
      .code_updated (code_updated),
      .pending      (pending),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every code_updated pulse must match the next queued code.
   initial begin
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && code_updated === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_update: got %0h expected none",
                        dac_code);
            end else begin
               e = exp_q.pop_front();
               check("update_code", 32'(dac_code), 32'(e));
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      pend_v = 1'b0;
      pend_w = '0;
      ov_m   = 1'b0;
      fe_m   = 1'b0;
      dac_m  = RC;
      exp_q.delete();
   endfunction

   function automatic void model_period();
      if (pend_v) begin
         exp_q.push_back(pend_w);
         dac_m  = pend_w;
         pend_v = 1'b0;
      end
   endfunction

   function automatic void model_commit(input logic [15:0] w,
                                        input int n);
      if (n == DW) begin
         if (pend_v) ov_m = 1'b1;
         pend_w = w[11:0];
         pend_v = 1'b1;
      end else begin
         fe_m = 1'b1;
      end
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_pending"}, 32'(pending), 32'(pend_v));
      check({tag, "_overrun"}, 32'(overrun), 32'(ov_m));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(fe_m));
      check({tag, "_dac_code"}, 32'(dac_code), 32'(dac_m));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      model_reset();
      wait_clk(4);
   endtask

   task automatic shift_bits(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = w[i];
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   // align=1 places period_start on the COMMIT cycle: cs_n rise is
   // registered through two sync flops, then one cycle into COMMIT.
   task automatic send_frame(input logic [15:0] w, input int n,
                             input bit align);
      wait_clk(1);
      cs_n = 1'b0;
      wait_clk(5);
      shift_bits(w, n);
      wait_clk(4);
      cs_n = 1'b1;
      if (align) begin
         wait_clk(3);
         period_start = 1'b1;
         model_period();
         wait_clk(1);
         period_start = 1'b0;
         model_commit(w, n);
         wait_clk(5);
      end else begin
         wait_clk(6);
         model_commit(w, n);
      end
   endtask

   task automatic pulse_period();
      period_start = 1'b1;
      model_period();
      wait_clk(1);
      period_start = 1'b0;
      wait_clk(2);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      wait_clk(1);
      clr_flags = 1'b0;
      ov_m = 1'b0;
      fe_m = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      logic [11:0] v;
      period_start = 1'b0;
      clr_flags    = 1'b0;
      rst_n        = 1'b0;
      sclk         = 1'b0;
      cs_n         = 1'b1;
      mosi         = 1'b0;
      model_reset();
      wait_clk(3);
      check_state("reset");
      check("reset_code_updated", 32'(code_updated), 32'd0);
      rst_n = 1'b1;
      wait_clk(4);

      // Basic frame then period boundary.
      send_frame(16'hA5C, 12, 1'b0);
      check_state("t1_frame");
      pulse_period();
      check_state("t1_period");

      // Overrun.
      send_frame(16'h123, 12, 1'b0);
      send_frame(16'h456, 12, 1'b0);
      check_state("t2_frames");
      pulse_period();
      check_state("t2_period");
      pulse_clr();
      check_state("t2_clr");

      // Short and long frames.
      do_reset();
      send_frame(16'h07FF, 11, 1'b0);
      check_state("t3_short");
      send_frame(16'h1ABC, 13, 1'b0);
      check_state("t3_long");
      send_frame(16'hFFF, 12, 1'b0);
      pulse_period();
      check_state("t3_valid");
      pulse_clr();

      // Commit aligned with period_start.
      send_frame(16'h001, 12, 1'b0);
      send_frame(16'h002, 12, 1'b1);
      check_state("t4_align");
      pulse_period();
      check_state("t4_next");

      // Reset mid-frame.
      send_frame(16'h3C3, 12, 1'b0);
      wait_clk(1);
      cs_n = 1'b0;
      wait_clk(5);
      shift_bits(16'h0AA, 6);
      rst_n = 1'b0;
      wait_clk(2);
      cs_n = 1'b1;
      sclk = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      model_reset();
      wait_clk(5);
      check_state("t5_reset");
      check("t5_code_updated", 32'(code_updated), 32'd0);
      send_frame(16'h7FF, 12, 1'b0);
      pulse_period();
      check_state("t5_frame");

      // sclk activity with cs_n high is ignored.
      for (int i = 0; i < 12; i++) begin
         mosi = 1'($urandom_range(0, 1));
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(6);
      check_state("t6_idle_sclk");
      pulse_period();
      check_state("t6_period");

      // Randomised traffic.
      for (int i = 0; i < 10; i++) begin
         v = 12'($urandom_range(0, 4095));
         send_frame({4'h0, v}, 12, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) pulse_period();
         check_state("rand");
         if ($urandom_range(0, 2) == 0) pulse_clr();
      end
      pulse_period();
      check_state("final");
      wait_clk(3);
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
